ycbcr2rgb_pipe: RTL and testbench



---
 rtl/ycbcr2rgb_pipe.sv | 168 ++++++++++++++++
 tb/tb_ycbcr2rgb_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb_pipe.sv
// YCbCr to RGB colour converter with a three-stage elastic valid/ready pipeline.
// Handles full-range (JFIF) and studio-range (BT.601) input, selected per pixel.
// Results are rounded to nearest and clamped to 0..2^DW-1.
// A pixel accepted at a rising edge reaches the output register two edges later,
// so it is presented in the third cycle counted from the accepting edge.
module ycbcr2rgb_pipe #(
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          rst_b,
  input  logic          mode_i,
  input  logic [DW-1:0] y_i,
  input  logic [DW-1:0] cb_i,
  input  logic [DW-1:0] cr_i,
  input  logic          vld_i,
  output logic          rdy_o,
  output logic [DW-1:0] r_o,
  output logic [DW-1:0] g_o,
  output logic [DW-1:0] b_o,
  output logic          vld_o,
  input  logic          rdy_i
);

  localparam int W = DW + 12;

  localparam logic signed [W-1:0] H_C   = W'(2 ** (DW - 1));
  localparam logic signed [W-1:0] L_C   = W'(2 ** (DW - 4));
  localparam logic signed [W-1:0] MAX_C = W'(2 ** DW - 1);
  localparam logic signed [W-1:0] RND_C = W'(128);

  // Q8 coefficients: full range (_J) and studio range (_S)
  localparam logic signed [W-1:0] KY_J  = W'(256);
  localparam logic signed [W-1:0] KR_J  = W'(359);
  localparam logic signed [W-1:0] KGB_J = W'(88);
  localparam logic signed [W-1:0] KGR_J = W'(183);
  localparam logic signed [W-1:0] KB_J  = W'(454);
  localparam logic signed [W-1:0] KY_S  = W'(298);
  localparam logic signed [W-1:0] KR_S  = W'(409);
  localparam logic signed [W-1:0] KGB_S = W'(100);
  localparam logic signed [W-1:0] KGR_S = W'(208);
  localparam logic signed [W-1:0] KB_S  = W'(516);

  logic adv1, adv2, adv3;
  logic v1_q, v2_q, v3_q;

  logic                m1_q,  m1_d;
  logic signed [W-1:0] dy_q,  dy_d;
  logic signed [W-1:0] dcb_q, dcb_d;
  logic signed [W-1:0] dcr_q, dcr_d;

  logic signed [W-1:0] ty_q, ty_d;
  logic signed [W-1:0] tr_q, tr_d;
  logic signed [W-1:0] tg_q, tg_d;
  logic signed [W-1:0] tb_q, tb_d;

  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] g_q, g_d;
  logic [DW-1:0] b_q, b_d;

  logic signed [W-1:0] y_ext, cb_ext, cr_ext;
  logic signed [W-1:0] k_y, k_r, k_gb, k_gr, k_b;
  logic signed [W-1:0] sum_r, sum_g, sum_b;

  // Saturate an already-shifted signed result to the output range.
  function automatic logic [DW-1:0] clamp(input logic signed [W-1:0] x);
    if (x[W-1]) begin
      return '0;
    end else if (x > MAX_C) begin
      return '1;
    end else begin
      return x[DW-1:0];
    end
  endfunction

  // Advance chain: a stage moves when it is empty or the stage after it moves.
  always_comb begin
    adv3 = !v3_q | rdy_i;
    adv2 = !v2_q | adv3;
    adv1 = !v1_q | adv2;
  end

  assign rdy_o = adv1;
  assign vld_o = v3_q;
  assign r_o   = r_q;
  assign g_o   = g_q;
  assign b_o   = b_q;

  // Stage 1 next state: remove chroma offset and, for studio range, black level.
  always_comb begin
    y_ext  = W'(y_i);
    cb_ext = W'(cb_i);
    cr_ext = W'(cr_i);
    m1_d   = mode_i;
    dy_d   = mode_i ? (y_ext - L_C) : y_ext;
    dcb_d  = cb_ext - H_C;
    dcr_d  = cr_ext - H_C;
  end

  // Stage 2 next state: coefficient products chosen by the pixel's own mode.
  always_comb begin
    k_y  = m1_q ? KY_S  : KY_J;
    k_r  = m1_q ? KR_S  : KR_J;
    k_gb = m1_q ? KGB_S : KGB_J;
    k_gr = m1_q ? KGR_S : KGR_J;
    k_b  = m1_q ? KB_S  : KB_J;
    ty_d = dy_q * k_y;
    tr_d = dcr_q * k_r;
    tg_d = -(dcb_q * k_gb) - (dcr_q * k_gr);
    tb_d = dcb_q * k_b;
  end

  // Stage 3 next state: round, shift, clamp; a bubble loads zeros.
  always_comb begin
    sum_r = ty_q + tr_q + RND_C;
    sum_g = ty_q + tg_q + RND_C;
    sum_b = ty_q + tb_q + RND_C;
    r_d   = '0;
    g_d   = '0;
    b_d   = '0;
    if (v2_q) begin
      r_d = clamp(sum_r >>> 8);
      g_d = clamp(sum_g >>> 8);
      b_d = clamp(sum_b >>> 8);
    end
  end

  // Pipeline registers: each stage loads from upstream only when it advances.
  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      m1_q  <= 1'b0;
      dy_q  <= '0;
      dcb_q <= '0;
      dcr_q <= '0;
      ty_q  <= '0;
      tr_q  <= '0;
      tg_q  <= '0;
      tb_q  <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      if (adv1) begin
        v1_q  <= vld_i;
        m1_q  <= m1_d;
        dy_q  <= dy_d;
        dcb_q <= dcb_d;
        dcr_q <= dcr_d;
      end
      if (adv2) begin
        v2_q <= v1_q;
        ty_q <= ty_d;
        tr_q <= tr_d;
        tg_q <= tg_d;
        tb_q <= tb_d;
      end
      if (adv3) begin
        v3_q <= v2_q;
        r_q  <= r_d;
        g_q  <= g_d;
        b_q  <= b_d;
      end
    end
  end

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// Bench for ycbcr2rgb_pipe: directed DW=8 vectors, back-pressure, reset mid-stream,
// and a DW=10 corner/random sweep against an integer reference model.
module tb_ycbcr2rgb_pipe;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic rst_b;

  logic       mode8, vld8_i, rdy8_o, vld8_o, rdy8_i;
  logic [7:0] y8, cb8, cr8, r8, g8, b8;

  logic       mode10, vld10_i, rdy10_o, vld10_o, rdy10_i;
  logic [9:0] y10, cb10, cr10, r10, g10, b10;

  int n_checks = 0;
  int n_fail   = 0;

  ycbcr2rgb_pipe #(.DW(8)) u_dut8 (
    .clk_sys(clk_sys), .rst_b(rst_b), .mode_i(mode8),
    .y_i(y8), .cb_i(cb8), .cr_i(cr8), .vld_i(vld8_i), .rdy_o(rdy8_o),
    .r_o(r8), .g_o(g8), .b_o(b8), .vld_o(vld8_o), .rdy_i(rdy8_i)
  );

  ycbcr2rgb_pipe #(.DW(10)) u_dut10 (
    .clk_sys(clk_sys), .rst_b(rst_b), .mode_i(mode10),
    .y_i(y10), .cb_i(cb10), .cr_i(cr10), .vld_i(vld10_i), .rdy_o(rdy10_o),
    .r_o(r10), .g_o(g10), .b_o(b10), .vld_o(vld10_o), .rdy_i(rdy10_i)
  );

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int floor256(input int x);
    if (x >= 0) return x / 256;
    return -((-x + 255) / 256);
  endfunction

  function automatic int sat(input int x, input int mx);
    if (x < 0) return 0;
    if (x > mx) return mx;
    return x;
  endfunction

  function automatic void model(input int dw, input bit m, input int y, input int cb,
                                input int cr, output int r, output int g, output int b);
    int h, l, mx, dy, dcb, dcr, ty, sr, sg, sb;
    h   = 1 << (dw - 1);
    l   = 1 << (dw - 4);
    mx  = (1 << dw) - 1;
    dcb = cb - h;
    dcr = cr - h;
    if (!m) begin
      dy = y;
      ty = dy * 256;
      sr = ty + 359 * dcr;
      sg = ty - 88 * dcb - 183 * dcr;
      sb = ty + 454 * dcb;
    end else begin
      dy = y - l;
      ty = dy * 298;
      sr = ty + 409 * dcr;
      sg = ty - 100 * dcb - 208 * dcr;
      sb = ty + 516 * dcb;
    end
    r = sat(floor256(sr + 128), mx);
    g = sat(floor256(sg + 128), mx);
    b = sat(floor256(sb + 128), mx);
  endfunction

  task automatic test_reset;
    rst_b   = 1'b0;
    vld8_i  = 1'b0; rdy8_i  = 1'b1; mode8  = 1'b0; y8  = '0; cb8  = '0; cr8  = '0;
    vld10_i = 1'b0; rdy10_i = 1'b1; mode10 = 1'b0; y10 = '0; cb10 = '0; cr10 = '0;
    tick;
    tick;
    n_checks++;
    if (vld8_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_vld8 got %b want 0", vld8_o);
    end
    n_checks++;
    if ({r8, g8, b8} !== 24'h0) begin
      n_fail++; $display("FAIL reset_rgb8 got %0d,%0d,%0d want 0,0,0", r8, g8, b8);
    end
    n_checks++;
    if (vld10_o !== 1'b0 || {r10, g10, b10} !== 30'h0) begin
      n_fail++; $display("FAIL reset_dut10 got vld=%b rgb=%0d,%0d,%0d want 0", vld10_o, r10, g10, b10);
    end
    rst_b = 1'b1;
    #1;
    n_checks++;
    if (rdy8_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_rdy8 got %b want 1", rdy8_o);
    end
  endtask

  // Back-to-back directed vectors with rdy_i high; pixel k is visible three samples later.
  task automatic test_directed;
    localparam int N = 8;
    int tm [N] = '{0, 0, 0, 1, 1, 1, 0, 1};
    int ty [N] = '{128, 255, 0, 16, 16, 235, 100, 100};
    int tcb[N] = '{128, 128, 128, 16, 128, 128, 90, 200};
    int tcr[N] = '{128, 255, 0, 128, 128, 128, 160, 60};
    int er [N] = '{128, 255, 0, 0, 0, 255, 145, 0};
    int eg [N] = '{128, 164, 92, 44, 0, 255, 90, 125};
    int eb [N] = '{128, 255, 0, 0, 0, 255, 33, 243};
    rdy8_i = 1'b1;
    for (int k = 0; k < N + 3; k++) begin
      if (k < N) begin
        vld8_i = 1'b1; mode8 = tm[k][0];
        y8 = 8'(ty[k]); cb8 = 8'(tcb[k]); cr8 = 8'(tcr[k]);
      end else begin
        vld8_i = 1'b0; y8 = 8'hxx; cb8 = 8'hxx; cr8 = 8'hxx;
      end
      #1;
      if (k < N) begin
        n_checks++;
        if (rdy8_o !== 1'b1) begin
          n_fail++; $display("FAIL directed_rdy k=%0d got %b want 1", k, rdy8_o);
        end
      end
      n_checks++;
      if (k < 3) begin
        if (vld8_o !== 1'b0) begin
          n_fail++; $display("FAIL directed_latency k=%0d vld got %b want 0", k, vld8_o);
        end
      end else begin
        if (vld8_o !== 1'b1 || r8 !== 8'(er[k-3]) || g8 !== 8'(eg[k-3]) || b8 !== 8'(eb[k-3])) begin
          n_fail++;
          $display("FAIL directed_px%0d got vld=%b rgb=%0d,%0d,%0d want vld=1 rgb=%0d,%0d,%0d",
                   k - 3, vld8_o, r8, g8, b8, er[k-3], eg[k-3], eb[k-3]);
        end
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    localparam int N = 8;
    int pm [N], py[N], pcb[N], pcr[N];
    int qr [$], qg[$], qb[$];
    int acc, recv, cyc, xr, xg, xb;
    bit prev_stall, saw_full;
    logic [7:0] pr, pg, pb;
    for (int i = 0; i < N; i++) begin
      pm[i]  = (i % 3 == 1) ? 1 : 0;
      py[i]  = int'($urandom_range(0, 255));
      pcb[i] = int'($urandom_range(0, 255));
      pcr[i] = int'($urandom_range(0, 255));
    end
    acc = 0; recv = 0; cyc = 0; prev_stall = 1'b0; saw_full = 1'b0;
    pr = '0; pg = '0; pb = '0;
    while (recv < N && cyc < 300) begin
      rdy8_i = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      if (acc < N) begin
        vld8_i = 1'b1; mode8 = pm[acc][0];
        y8 = 8'(py[acc]); cb8 = 8'(pcb[acc]); cr8 = 8'(pcr[acc]);
      end else begin
        vld8_i = 1'b0;
      end
      #1;
      n_checks++;
      if (rdy8_o !== !((acc - recv) == 3 && !rdy8_i)) begin
        n_fail++; $display("FAIL bp_rdy cyc=%0d held=%0d rdy_i=%b got %b", cyc, acc - recv, rdy8_i, rdy8_o);
      end
      if ((acc - recv) == 3 && !rdy8_i) saw_full = 1'b1;
      if (prev_stall) begin
        n_checks++;
        if (vld8_o !== 1'b1 || r8 !== pr || g8 !== pg || b8 !== pb) begin
          n_fail++;
          $display("FAIL bp_stable cyc=%0d got vld=%b rgb=%0d,%0d,%0d want vld=1 rgb=%0d,%0d,%0d",
                   cyc, vld8_o, r8, g8, b8, pr, pg, pb);
        end
      end
      if (vld8_o !== 1'b1) begin
        n_checks++;
        if ({r8, g8, b8} !== 24'h0) begin
          n_fail++; $display("FAIL bp_bubble_zero cyc=%0d got %0d,%0d,%0d want 0,0,0", cyc, r8, g8, b8);
        end
      end
      if (vld8_o === 1'b1 && rdy8_i) begin
        n_checks++;
        if (qr.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_output cyc=%0d got rgb=%0d,%0d,%0d want none", cyc, r8, g8, b8);
        end else begin
          xr = qr.pop_front(); xg = qg.pop_front(); xb = qb.pop_front();
          if (r8 !== 8'(xr) || g8 !== 8'(xg) || b8 !== 8'(xb)) begin
            n_fail++;
            $display("FAIL bp_px%0d got %0d,%0d,%0d want %0d,%0d,%0d", recv, r8, g8, b8, xr, xg, xb);
          end
        end
        recv++;
      end
      if (vld8_i && rdy8_o === 1'b1) begin
        model(8, pm[acc][0], py[acc], pcb[acc], pcr[acc], xr, xg, xb);
        qr.push_back(xr); qg.push_back(xg); qb.push_back(xb);
        acc++;
      end
      prev_stall = (vld8_o === 1'b1) && !rdy8_i;
      pr = r8; pg = g8; pb = b8;
      tick;
      cyc++;
    end
    vld8_i = 1'b0;
    n_checks++;
    if (recv != N) begin
      n_fail++; $display("FAIL bp_timeout got %0d outputs want %0d", recv, N);
    end
    n_checks++;
    if (!saw_full) begin
      n_fail++; $display("FAIL bp_never_full got held<3 throughout want 3 held");
    end
  endtask

  task automatic test_reset_midstream;
    bit full, leaked;
    full = 1'b0; leaked = 1'b0;
    rdy8_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vld8_i = 1'b1; mode8 = 1'b0; y8 = 8'd200; cb8 = 8'd100; cr8 = 8'd150;
      #1;
      if (rdy8_o === 1'b0) begin
        full = 1'b1;
        break;
      end
      tick;
    end
    n_checks++;
    if (!full || vld8_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_fill got full=%b vld=%b want 1,1", full, vld8_o);
    end
    vld8_i = 1'b0;
    rst_b  = 1'b0;
    tick;
    n_checks++;
    if (vld8_o !== 1'b0 || {r8, g8, b8} !== 24'h0) begin
      n_fail++; $display("FAIL rstmid_out got vld=%b rgb=%0d,%0d,%0d want 0,0,0,0", vld8_o, r8, g8, b8);
    end
    rst_b = 1'b1;
    #1;
    n_checks++;
    if (rdy8_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_rdy got %b want 1", rdy8_o);
    end
    rdy8_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (vld8_o !== 1'b0) leaked = 1'b1;
    end
    n_checks++;
    if (leaked) begin
      n_fail++; $display("FAIL rstmid_leak got pre-reset pixel at output want none");
    end
  endtask

  task automatic test_dw10_sweep;
    localparam int N = 56;
    int sm[N], sy[N], scb[N], scr[N], er[N], eg[N], eb[N];
    for (int i = 0; i < 16; i++) begin
      sm[i]  = (i >> 3) & 1;
      sy[i]  = (i & 1) ? 1023 : 0;
      scb[i] = (i & 2) ? 1023 : 0;
      scr[i] = (i & 4) ? 1023 : 0;
    end
    for (int i = 16; i < N; i++) begin
      sm[i]  = int'($urandom_range(0, 1));
      sy[i]  = int'($urandom_range(0, 1023));
      scb[i] = int'($urandom_range(0, 1023));
      scr[i] = int'($urandom_range(0, 1023));
    end
    for (int i = 0; i < N; i++) model(10, sm[i][0], sy[i], scb[i], scr[i], er[i], eg[i], eb[i]);
    // Hand-worked corners: full range Y=1023,Cb=0,Cr=1023 and studio Y=0,Cb=1023,Cr=0.
    er[5] = 1023; eg[5] = 834; eb[5] = 115;
    er[10] = 0;   eg[10] = 142; eb[10] = 955;
    rdy10_i = 1'b1;
    for (int k = 0; k < N + 3; k++) begin
      if (k < N) begin
        vld10_i = 1'b1; mode10 = sm[k][0];
        y10 = 10'(sy[k]); cb10 = 10'(scb[k]); cr10 = 10'(scr[k]);
      end else begin
        vld10_i = 1'b0;
      end
      #1;
      if (k >= 3) begin
        n_checks++;
        if (vld10_o !== 1'b1 || r10 !== 10'(er[k-3]) || g10 !== 10'(eg[k-3]) || b10 !== 10'(eb[k-3])) begin
          n_fail++;
          $display("FAIL dw10_px%0d m=%0d ycbcr=%0d,%0d,%0d got vld=%b rgb=%0d,%0d,%0d want %0d,%0d,%0d",
                   k - 3, sm[k-3], sy[k-3], scb[k-3], scr[k-3], vld10_o, r10, g10, b10,
                   er[k-3], eg[k-3], eb[k-3]);
        end
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_midstream;
    test_dw10_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
